// File: rtl/clk_meter_pkg.sv
// Shared constants for the clock period meter: FSM encoding, default sizing and averaging depth.
package clk_meter_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE    = 1'b0;
  localparam state_t MEASURE = 1'b1;

  localparam int unsigned DEF_N       = 16;
  localparam int unsigned DEF_TIMEOUT = 50000;

  // Averaging depth must stay a power of two so the mean is a plain shift.
  localparam int unsigned AVG_DEPTH = 4;
  localparam int unsigned AVG_SHIFT = $clog2(AVG_DEPTH);

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchroniser for an asynchronous input followed by a one-cycle rising-edge detector.
module sync_rise_det (
  input  logic clk_in,
  input  logic ar,
  input  logic d,
  output logic rise
);

  logic s1_reg;
  logic s2_reg;
  logic s3_reg;

  always_ff @(posedge clk_in or negedge ar) begin
    if (!ar) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= d;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  // s2 is the first metastability-safe copy; s3 is its one-cycle history.
  assign rise = s2_reg & ~s3_reg;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of sig_in in clk_in cycles and offers it on a valid/ready port.
// Define CLK_PERIOD_METER_AVG_EN to present the mean of every 4 consecutive periods instead.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int unsigned N       = DEF_N,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk_in,
  input  logic         ar,
  input  logic         sig_in,
  output logic [N-1:0] period,
  output logic         valid,
  input  logic         ready,
  output logic         overrun,
  output logic         timeout
);

  localparam logic [N-1:0] TIMEOUT_CNT = N'(TIMEOUT);
  localparam logic [N-1:0] CNT_ONE     = N'(1);

  logic         rise;
  state_t       state_reg;
  state_t       state_next;
  logic [N-1:0] count_reg;
  logic [N-1:0] count_next;
  logic         timeout_reg;
  logic         timeout_next;
  logic [N-1:0] period_reg;
  logic [N-1:0] period_next;
  logic         valid_reg;
  logic         valid_next;
  logic         overrun_reg;
  logic         overrun_next;
  logic         capture;
  logic         expire;
  logic         transfer;
  logic         emit;
  logic [N-1:0] result;

  sync_rise_det u_sync (
    .clk_in (clk_in),
    .ar     (ar),
    .d      (sig_in),
    .rise   (rise)
  );

  // A rise in the same cycle the count hits the limit still counts as a capture.
  assign capture  = (state_reg == MEASURE) && rise;
  assign expire   = (state_reg == MEASURE) && !rise && (count_reg == TIMEOUT_CNT);
  assign transfer = valid_reg && ready;

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    timeout_next = timeout_reg;
    if (rise) begin
      timeout_next = 1'b0;
    end
    case (state_reg)
      IDLE: begin
        if (rise) begin
          state_next = MEASURE;
          count_next = CNT_ONE;
        end
      end
      MEASURE: begin
        if (rise) begin
          count_next = CNT_ONE;
        end else if (expire) begin
          state_next   = IDLE;
          count_next   = '0;
          timeout_next = 1'b1;
        end else begin
          count_next = count_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

`ifdef CLK_PERIOD_METER_AVG_EN
  logic [N+AVG_SHIFT-1:0] acc_reg;
  logic [N+AVG_SHIFT-1:0] acc_next;
  logic [N+AVG_SHIFT-1:0] acc_sum;
  logic [AVG_SHIFT-1:0]   acc_cnt_reg;
  logic [AVG_SHIFT-1:0]   acc_cnt_next;

  assign acc_sum = acc_reg + {{AVG_SHIFT{1'b0}}, count_reg};

  always_comb begin
    emit         = 1'b0;
    result       = N'(acc_sum >> AVG_SHIFT);
    acc_next     = acc_reg;
    acc_cnt_next = acc_cnt_reg;
    if (capture) begin
      if (acc_cnt_reg == AVG_SHIFT'(AVG_DEPTH - 1)) begin
        emit         = 1'b1;
        acc_next     = '0;
        acc_cnt_next = '0;
      end else begin
        acc_next     = acc_sum;
        acc_cnt_next = acc_cnt_reg + 1'b1;
      end
    end else if (expire) begin
      // A stalled input makes the partial group meaningless.
      acc_next     = '0;
      acc_cnt_next = '0;
    end
  end

  always_ff @(posedge clk_in or negedge ar) begin
    if (!ar) begin
      acc_reg     <= '0;
      acc_cnt_reg <= '0;
    end else begin
      acc_reg     <= acc_next;
      acc_cnt_reg <= acc_cnt_next;
    end
  end
`else
  assign emit   = capture;
  assign result = count_reg;
`endif

  // A new result always wins over a coincident transfer, so valid never drops then.
  always_comb begin
    period_next  = period_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    if (emit) begin
      period_next = result;
      valid_next  = 1'b1;
      if (valid_reg && !ready) begin
        overrun_next = 1'b1;
      end
    end else if (transfer) begin
      valid_next   = 1'b0;
      overrun_next = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge ar) begin
    if (!ar) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      timeout_reg <= 1'b0;
      period_reg  <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      timeout_reg <= timeout_next;
      period_reg  <= period_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

  assign period  = period_reg;
  assign valid   = valid_reg;
  assign overrun = overrun_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter (N=16, TIMEOUT=1000); honours CLK_PERIOD_METER_AVG_EN.
module tb_clk_period_meter;

  localparam int TMO = 1000;

  logic        clk;
  logic        ar;
  logic        sig_in;
  logic        ready;
  logic [15:0] period;
  logic        valid;
  logic        overrun;
  logic        timeout;

  int n_checks;
  int n_errors;
  bit sb_on;
  int exp_q[$];
  bit armed;
  int grp_sum;
  int grp_n;

  clk_period_meter #(.N(16), .TIMEOUT(TMO)) dut (
    .clk_in  (clk),
    .ar      (ar),
    .sig_in  (sig_in),
    .period  (period),
    .valid   (valid),
    .ready   (ready),
    .overrun (overrun),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          hi;
    int          lo;
    logic        rdy;
    logic        ev;
    logic [15:0] ep;
    logic        eo;
    logic        ev2;
    logic        eo2;
  } vec_t;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: works on whole gaps between sig_in rises.
  task automatic model_rise(input int gap);
    if (armed) begin
      if (gap <= TMO) begin
`ifdef CLK_PERIOD_METER_AVG_EN
        grp_sum += gap;
        grp_n++;
        if (grp_n == 4) begin
          exp_q.push_back(grp_sum / 4);
          grp_sum = 0;
          grp_n   = 0;
        end
`else
        exp_q.push_back(gap);
`endif
      end else begin
        grp_sum = 0;
        grp_n   = 0;
      end
    end
    armed = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb_on && ar && valid && ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got period %0d, expected no result", period);
      end else begin
        int e;
        e = exp_q.pop_front();
        $display("xfer period=%0d expected=%0d", period, e);
        if (period !== 16'(e)) begin
          n_errors++;
          $display("FAIL sb_period: got %0d, expected %0d", period, e);
        end
      end
    end
  end

  initial begin
    vec_t vecs[8];
    int   prev_gap;
    int   gap;
    int   hi;

    n_checks = 0;
    n_errors = 0;
    sb_on    = 1'b0;
    armed    = 1'b0;
    grp_sum  = 0;
    grp_n    = 0;
    ar       = 1'b0;
    sig_in   = 1'b0;
    ready    = 1'b1;

    tick(3);
    chk("reset_period", 32'(period), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_overrun", 32'(overrun), 0);
    chk("reset_timeout", 32'(timeout), 0);
    ar = 1'b1;
    tick(3);

`ifndef CLK_PERIOD_METER_AVG_EN
    // Each row is one sig_in period; the gap measured at row i is row i-1's hi+lo.
    vecs[0] = '{50, 50, 1'b1, 1'b0, 16'd0,   1'b0, 1'b0, 1'b0};
    vecs[1] = '{50, 50, 1'b1, 1'b1, 16'd100, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{60, 60, 1'b1, 1'b1, 16'd100, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{40, 40, 1'b0, 1'b1, 16'd120, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{30, 30, 1'b0, 1'b1, 16'd80,  1'b1, 1'b1, 1'b1};
    vecs[5] = '{70, 30, 1'b1, 1'b1, 16'd60,  1'b1, 1'b0, 1'b0};
    vecs[6] = '{60, 60, 1'b0, 1'b1, 16'd100, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{50, 50, 1'b0, 1'b1, 16'd120, 1'b1, 1'b1, 1'b1};

    for (int i = 0; i < 8; i++) begin
      sig_in = 1'b1;
      tick(2);
      ready = vecs[i].rdy;
      tick(1);
      $display("vec %0d: valid=%0d period=%0d overrun=%0d", i, valid, period, overrun);
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_period", i), 32'(period), 32'(vecs[i].ep));
      chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].eo));
      tick(1);
      chk($sformatf("vec%0d_valid_next", i), 32'(valid), 32'(vecs[i].ev2));
      chk($sformatf("vec%0d_overrun_next", i), 32'(overrun), 32'(vecs[i].eo2));
      tick(vecs[i].hi - 4);
      sig_in = 1'b0;
      tick(vecs[i].lo);
    end

    // One-cycle accept clears both the pending result and the overrun flag.
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    chk("accept_valid", 32'(valid), 0);
    chk("accept_overrun", 32'(overrun), 0);
    chk("accept_period_hold", 32'(period), 120);
    ready = 1'b1;

    // sig_in stops high: timeout fires exactly TMO cycles after the capture edge.
    sig_in = 1'b1;
    tick(1002);
    chk("tmo_before", 32'(timeout), 0);
    tick(1);
    $display("timeout seq: timeout=%0d valid=%0d", timeout, valid);
    chk("tmo_set", 32'(timeout), 1);
    chk("tmo_valid", 32'(valid), 0);
    sig_in = 1'b0;
    tick(20);
    sig_in = 1'b1;
    tick(3);
    chk("tmo_clear", 32'(timeout), 0);
    chk("tmo_rearm_valid", 32'(valid), 0);
    tick(47);
    sig_in = 1'b0;
    tick(50);
    sig_in = 1'b1;
    tick(3);
    chk("tmo_after_valid", 32'(valid), 1);
    chk("tmo_after_period", 32'(period), 100);

    // Build up valid+overrun, then reset 37 cycles into a measurement.
    ready = 1'b0;
    tick(17);
    sig_in = 1'b0;
    tick(80);
    sig_in = 1'b1;
    tick(3);
    tick(17);
    sig_in = 1'b0;
    tick(80);
    sig_in = 1'b1;
    tick(3);
    chk("pre_reset_overrun", 32'(overrun), 1);
    tick(17);
    sig_in = 1'b0;
    tick(17);
    #2 ar = 1'b0;
    #1;
    $display("async reset: period=%0d valid=%0d overrun=%0d timeout=%0d", period, valid, overrun, timeout);
    chk("ar_period", 32'(period), 0);
    chk("ar_valid", 32'(valid), 0);
    chk("ar_overrun", 32'(overrun), 0);
    chk("ar_timeout", 32'(timeout), 0);
    @(negedge clk);
    ar    = 1'b1;
    ready = 1'b1;
    tick(5);
    sig_in = 1'b1;
    tick(3);
    chk("post_ar_arm_valid", 32'(valid), 0);
    tick(47);
    sig_in = 1'b0;
    tick(50);
    sig_in = 1'b1;
    tick(3);
    chk("post_ar_valid", 32'(valid), 1);
    chk("post_ar_period", 32'(period), 100);
    tick(17);
    sig_in = 1'b0;
    tick(20);
`else
    begin
      int gaps[4];
      gaps = '{100, 102, 98, 101};
      for (int i = 0; i < 5; i++) begin
        sig_in = 1'b1;
        tick(3);
        $display("avg rise %0d: valid=%0d period=%0d", i, valid, period);
        if (i < 4) begin
          chk($sformatf("avg_rise%0d_valid", i), 32'(valid), 0);
          tick(37);
          sig_in = 1'b0;
          tick(gaps[i] - 40);
        end else begin
          chk("avg_valid", 32'(valid), 1);
          chk("avg_period", 32'(period), 100);
          tick(1);
          chk("avg_valid_next", 32'(valid), 0);
        end
      end
      tick(17);
      sig_in = 1'b0;
      tick(20);
    end
`endif

    // Randomised run against the gap-level model, starting from a known IDLE.
    @(negedge clk);
    ar     = 1'b0;
    sig_in = 1'b0;
    ready  = 1'b1;
    tick(2);
    ar = 1'b1;
    tick(3);
    armed    = 1'b0;
    grp_sum  = 0;
    grp_n    = 0;
    exp_q.delete();
    sb_on    = 1'b1;
    prev_gap = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 10)      gap = TMO;
      else if (k == 20) gap = TMO + 1;
      else if (k == 30) gap = TMO + 200;
      else              gap = int'($urandom_range(300, 20));
      hi = int'($urandom_range(gap - 1, 1));
      model_rise(prev_gap);
      sig_in = 1'b1;
      tick(hi);
      sig_in = 1'b0;
      tick(gap - hi);
      prev_gap = gap;
    end
    model_rise(prev_gap);
    sig_in = 1'b1;
    tick(10);
    sig_in = 1'b0;
    tick(5);
    sb_on = 1'b0;
    chk("sb_drained", 32'(exp_q.size()), 0);
    chk("sb_overrun", 32'(overrun), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
